game_fsm: RTL and testbench
===========================

GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning lives granted at game start (1..3).
REQ-002 SHALL have parameter HOMES, default 5, meaning home arrivals required for WIN.
REQ-003 SHALL have parameter DEATH_FRAMES, default 60, meaning frame_tick count of the DEAD pause.
REQ-004 SHALL have parameter TIME_LIMIT, default 30, meaning round time in seconds.
REQ-005 SHALL have parameter FRAMES_PER_SEC, default 60, meaning frame_tick pulses per second.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-009 start_tick  in  1  one-cycle debounced start-button pulse.
REQ-010 collision  in  1  frog hit hazard (level, sampled each clk).
REQ-011 reached_end  in  1  frog reached a home slot (level, sampled each clk).
REQ-012 state  out  2  MENU=0, PLAYING=1, DEAD=2, WIN=3; drives frog state input.
REQ-013 respawn  out  1  one-cycle pulse; frog returns to init position.
REQ-014 lives  out  2  lives remaining.
REQ-015 homes  out  3  homes filled this game.
REQ-016 score  out  14  score, saturating at 9999.
REQ-017 time_left  out  6  whole seconds remaining in the current life.
REQ-018 game_over  out  1  high in MENU after losing the last life; cleared by start_tick.

Function
REQ-019 MENU: on start_tick -> PLAYING; load lives=LIVES, homes=0, score=0, time_left=TIME_LIMIT, frame sub-counter=0, clear game_over; pulse respawn in the same cycle as the transition.
REQ-020 PLAYING, collision=1 -> DEAD; lives decrements by 1; death counter loads DEATH_FRAMES.
REQ-021 PLAYING, time_left=0 -> handled identically to collision.
REQ-022 PLAYING, reached_end=1 and collision=0: score += 50 (saturating), homes += 1, time_left reloads, respawn pulses; if the new homes equals HOMES -> WIN, else remain PLAYING.
REQ-023 PLAYING, collision and reached_end in the same cycle: collision wins; no score or homes change.
REQ-024 PLAYING, frame_tick: the sub-counter increments; at FRAMES_PER_SEC-1 it wraps to 0 and time_left decrements by 1; time_left never goes below 0.
REQ-025 reached_end SHALL be acted on only on its rising edge (registered previous value), so one arrival scores once.
REQ-026 DEAD: each frame_tick decrements the death counter; collision, reached_end and start_tick are ignored.
REQ-027 DEAD, counter reaches 0 with lives>0 -> PLAYING; time_left reloads, sub-counter clears, respawn pulses.
REQ-028 DEAD, counter reaches 0 with lives=0 -> MENU; set game_over; hold score for display.
REQ-029 WIN: outputs frozen; start_tick -> MENU with game_over=0; score is held until the next game starts.
REQ-030 A frame_tick in the same cycle as a transition into DEAD SHALL NOT decrement the freshly loaded counter.
REQ-031 respawn SHALL never be high for two consecutive cycles.
REQ-032 All outputs SHALL be registered; every transition takes effect on the clk edge following the triggering input (latency 1).

Reset
REQ-033 reset SHALL override all inputs: state=MENU, respawn=0, lives=LIVES, homes=0, score=0, time_left=TIME_LIMIT, game_over=0, all internal counters 0, previous reached_end=0.
REQ-034 reset asserted in any state, including mid-DEAD countdown, SHALL return the block to MENU on the next edge.

Structure
REQ-035 The state enum (MENU/PLAYING/DEAD/WIN, 2-bit) and the score constants (home value 50, maximum 9999) SHALL live in a shared package game_pkg, which frog also imports.
REQ-036 The seconds timer (sub-counter plus time_left, with reload and enable) SHALL be a sub-module round_timer; everything else is flat.

Verification
REQ-037 Reset, then start_tick -> state=1, respawn high for exactly 1 cycle, lives=3, time_left=30.
REQ-038 PLAYING, collision 1 cycle -> state=2, lives=2; after 60 frame_ticks -> state=1 with a respawn pulse.
REQ-039 Three collisions, each followed by the full DEAD pause -> state=0, game_over=1, lives=0.
REQ-040 Five reached_end rising edges, each held 10 cycles -> score=250, homes=5, state=3, 5 respawn pulses.
REQ-041 No input for 1800 frame_ticks -> time_left steps 30..0, then state=2 and lives=2.
REQ-042 collision and reached_end in the same cycle -> state=2, score unchanged; reset during DEAD -> state=0 next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding and score constants used by
// game_fsm and by the frog block.
package game_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } game_state_e;

    localparam logic [1:0] ST_MENU    = MENU;
    localparam logic [1:0] ST_PLAYING = PLAYING;
    localparam logic [1:0] ST_DEAD    = DEAD;
    localparam logic [1:0] ST_WIN     = WIN;

    localparam logic [13:0] HOME_POINTS = 14'd50;
    localparam logic [13:0] SCORE_MAX   = 14'd9999;

    function automatic logic [13:0] add_home_score(input logic [13:0] score);
        return (score > SCORE_MAX - HOME_POINTS) ? SCORE_MAX : score + HOME_POINTS;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Per-life countdown: a frame sub-counter that steps time_left down once per
// second, with a reload that restarts the full round time.
module round_timer #(
    parameter int TIME_LIMIT     = 30,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reload,
    input  logic       enable,
    output logic [5:0] time_left
);

    localparam int                SUB_W     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [5:0]        TIME_INIT = 6'(TIME_LIMIT);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [5:0]       time_q, time_d;

    always_comb begin
        sub_d  = sub_q;
        time_d = time_q;
        if (reload) begin
            sub_d  = '0;
            time_d = TIME_INIT;
        end else if (enable) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                if (time_q != 6'd0) begin
                    time_d = time_q - 6'd1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q  <= '0;
            time_q <= TIME_INIT;
        end else begin
            sub_q  <= sub_d;
            time_q <= time_d;
        end
    end

    assign time_left = time_q;

endmodule

// File: rtl/game_fsm.sv
// Game flow controller: menu, play, death pause and win, with lives, homes,
// saturating score and the per-life round timer.
module game_fsm
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int HOMES          = 5,
    parameter int DEATH_FRAMES   = 60,
    parameter int TIME_LIMIT     = 30,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start_tick,
    input  logic        collision,
    input  logic        reached_end,
    output logic [1:0]  state,
    output logic        respawn,
    output logic [1:0]  lives,
    output logic [2:0]  homes,
    output logic [13:0] score,
    output logic [5:0]  time_left,
    output logic        game_over
);

    localparam int               DEATH_W    = (DEATH_FRAMES > 0) ? $clog2(DEATH_FRAMES + 1) : 1;
    localparam logic [DEATH_W-1:0] DEATH_INIT = DEATH_W'(DEATH_FRAMES);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [2:0]       HOMES_GOAL = 3'(HOMES);

    logic [1:0]         state_q, state_d;
    logic               respawn_q, respawn_d;
    logic [1:0]         lives_q, lives_d;
    logic [2:0]         homes_q, homes_d;
    logic [13:0]        score_q, score_d;
    logic               game_over_q, game_over_d;
    logic [DEATH_W-1:0] death_q, death_d, death_next;
    logic               reached_q;
    logic               timer_reload;
    logic               arrival;

    round_timer #(
        .TIME_LIMIT     (TIME_LIMIT),
        .FRAMES_PER_SEC (FRAMES_PER_SEC)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .reload    (timer_reload),
        .enable    (frame_tick && (state_q == ST_PLAYING)),
        .time_left (time_left)
    );

    // A frog that just respawned cannot be at a home, so arrivals are ignored
    // for that one cycle; this also keeps respawn from pulsing back to back.
    assign arrival    = reached_end && !reached_q && !respawn_q;
    assign death_next = (frame_tick && (death_q != '0)) ? death_q - 1'b1 : death_q;

    always_comb begin
        state_d      = state_q;
        respawn_d    = 1'b0;
        lives_d      = lives_q;
        homes_d      = homes_q;
        score_d      = score_q;
        game_over_d  = game_over_q;
        death_d      = death_q;
        timer_reload = 1'b0;
        case (state_q)
            ST_MENU: begin
                if (start_tick) begin
                    state_d      = ST_PLAYING;
                    lives_d      = LIVES_INIT;
                    homes_d      = 3'd0;
                    score_d      = 14'd0;
                    game_over_d  = 1'b0;
                    timer_reload = 1'b1;
                    respawn_d    = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (collision || (time_left == 6'd0)) begin
                    state_d = ST_DEAD;
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    death_d = DEATH_INIT;
                end else if (arrival) begin
                    score_d      = add_home_score(score_q);
                    homes_d      = homes_q + 3'd1;
                    timer_reload = 1'b1;
                    respawn_d    = 1'b1;
                    if (homes_d == HOMES_GOAL) begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_DEAD: begin
                death_d = death_next;
                if (death_next == '0) begin
                    if (lives_q != 2'd0) begin
                        state_d      = ST_PLAYING;
                        timer_reload = 1'b1;
                        respawn_d    = 1'b1;
                    end else begin
                        state_d     = ST_MENU;
                        game_over_d = 1'b1;
                    end
                end
            end
            ST_WIN: begin
                if (start_tick) begin
                    state_d     = ST_MENU;
                    game_over_d = 1'b0;
                end
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_MENU;
            respawn_q   <= 1'b0;
            lives_q     <= LIVES_INIT;
            homes_q     <= 3'd0;
            score_q     <= 14'd0;
            game_over_q <= 1'b0;
            death_q     <= '0;
            reached_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            respawn_q   <= respawn_d;
            lives_q     <= lives_d;
            homes_q     <= homes_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            death_q     <= death_d;
            reached_q   <= reached_end;
        end
    end

    assign state     = state_q;
    assign respawn   = respawn_q;
    assign lives     = lives_q;
    assign homes     = homes_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: a per-cycle vector table followed by
// hand-written death-pause, timeout, win and game-over sequences.
module tb_game_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        start_tick;
    logic        collision;
    logic        reached_end;
    logic [1:0]  state;
    logic        respawn;
    logic [1:0]  lives;
    logic [2:0]  homes;
    logic [13:0] score;
    logic [5:0]  time_left;
    logic        game_over;

    int checks   = 0;
    int failures = 0;
    int respawn_count;
    int respawn_back_to_back;
    logic respawn_prev;

    typedef struct {
        logic rst;
        logic start;
        logic frame;
        logic coll;
        logic reach;
        int   st;
        int   rsp;
        int   lv;
        int   hm;
        int   sc;
        int   tl;
        int   go;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    game_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start_tick  (start_tick),
        .collision   (collision),
        .reached_end (reached_end),
        .state       (state),
        .respawn     (respawn),
        .lives       (lives),
        .homes       (homes),
        .score       (score),
        .time_left   (time_left),
        .game_over   (game_over)
    );

    task automatic applyStimulus(input logic rst, input logic st, input logic fr,
                                 input logic co, input logic re);
        reset       = rst;
        start_tick  = st;
        frame_tick  = fr;
        collision   = co;
        reached_end = re;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int rsp, input int lv,
                             input int hm, input int sc, input int tl, input int go);
        checkOutput({tag, ".state"},     int'(state),     st);
        checkOutput({tag, ".respawn"},   int'(respawn),   rsp);
        checkOutput({tag, ".lives"},     int'(lives),     lv);
        checkOutput({tag, ".homes"},     int'(homes),     hm);
        checkOutput({tag, ".score"},     int'(score),     sc);
        checkOutput({tag, ".time_left"}, int'(time_left), tl);
        checkOutput({tag, ".game_over"}, int'(game_over), go);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_pulse();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic track_respawn();
        if (respawn) begin
            respawn_count++;
            if (respawn_prev) respawn_back_to_back++;
        end
        respawn_prev = respawn;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start_tick = 1'b0;
        collision = 1'b0; reached_end = 1'b0;

        //          rst start frame coll reach | st rsp lv hm sc tl go
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 30, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 30, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 3, 0, 0, 30, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3, 0, 0, 30, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 3, 1, 50, 30, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 3, 1, 50, 30, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3, 1, 50, 30, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 2, 1, 50, 30, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 2, 1, 50, 30, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 2, 1, 50, 30, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 30, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 3, 0, 0, 30, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0, 2, 0, 0, 30, 0};

        @(posedge clk);
        #1;
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].start, vecs[v].frame, vecs[v].coll, vecs[v].reach);
            check_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].rsp, vecs[v].lv,
                      vecs[v].hm, vecs[v].sc, vecs[v].tl, vecs[v].go);
        end

        // Death pause: the tick that entered DEAD must not count, so 59 ticks
        // leave it still dead and the 60th respawns.
        for (int i = 0; i < 59; i++) frame_pulse();
        checkOutput("pause59.state", int'(state), 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all("pause60", 1, 1, 2, 0, 0, 30, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pause60.respawn_drop", int'(respawn), 0);

        // Timeout: one second per 60 ticks, then the expired timer kills the frog.
        for (int n = 1; n <= 1800; n++) begin
            frame_pulse();
            if ((n % 60) == 0 || n == 1799) begin
                checkOutput($sformatf("timeout.tl@%0d", n), int'(time_left), 30 - n / 60);
            end
        end
        checkOutput("timeout.state", int'(state), 2);
        checkOutput("timeout.lives", int'(lives), 1);

        // Win: five arrivals, each held for 10 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        respawn_count = 0;
        respawn_back_to_back = 0;
        respawn_prev = 1'b0;
        for (int h = 0; h < 5; h++) begin
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                track_respawn();
            end
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                track_respawn();
            end
        end
        checkOutput("win.respawns", respawn_count, 5);
        checkOutput("win.back_to_back", respawn_back_to_back, 0);
        check_all("win", 3, 0, 3, 5, 250, 30, 0);
        for (int i = 0; i < 5; i++) frame_pulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_all("win_frozen", 3, 0, 3, 5, 250, 30, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("win_exit", 0, 0, 3, 5, 250, 30, 0);

        // Game over: score one home, then lose all three lives.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("newgame", 1, 1, 3, 0, 0, 30, 0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("death%0d.state", d), int'(state), 2);
            checkOutput($sformatf("death%0d.lives", d), int'(lives), 2 - d);
            for (int i = 0; i < 60; i++) frame_pulse();
            checkOutput($sformatf("death%0d.after", d), int'(state), (d < 2) ? 1 : 0);
        end
        check_all("gameover", 0, 0, 0, 1, 50, 30, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("restart", 1, 1, 3, 0, 0, 30, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
